// File: rtl/sram_port_arbiter_if.sv
// SRAM-like split request/response port shared by the arbiter's requesters and memory side.
// master drives the request phase; slave returns addr_ok/data_ok/rdata.
interface sram_port_arbiter_if #(
  parameter int ADDR_WD = 32,
  parameter int DATA_WD = 32
);
  logic                 req;
  logic                 wr;
  logic [1:0]           size;
  logic [ADDR_WD-1:0]   addr;
  logic [DATA_WD-1:0]   wdata;
  logic [DATA_WD/8-1:0] wstrb;
  logic                 addr_ok;
  logic                 data_ok;
  logic [DATA_WD-1:0]   rdata;

  modport master (
    output req, wr, size, addr, wdata, wstrb,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata, wstrb,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between instruction and data requesters, routing responses via an in-order ID FIFO.
// Define SRAM_ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed data-over-inst priority.
module sram_port_arbiter #(
  parameter int ADDR_WD   = 32,
  parameter int DATA_WD   = 32,
  parameter int MAX_OUTST = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  sram_port_arbiter_if.slave         inst,
  sram_port_arbiter_if.slave         data,
  sram_port_arbiter_if.master        mem,
  output logic                       arb_idle,
  output logic                       arb_err
);
  localparam int PTR_WD = $clog2(MAX_OUTST);
  localparam int CNT_WD = PTR_WD + 1;
  localparam logic [CNT_WD-1:0] FULL_CNT = CNT_WD'(MAX_OUTST);

  typedef enum logic {ID_INST = 1'b0, ID_DATA = 1'b1} req_id_e;

  req_id_e              id_fifo [MAX_OUTST];
  logic [PTR_WD-1:0]    head;
  logic [PTR_WD-1:0]    tail;
  logic [CNT_WD-1:0]    count;
  logic                 lock_valid;
  req_id_e              lock_id;
  logic                 grant_valid;
  req_id_e              grant_id;
  logic                 grant_req;
  logic                 accept;
  logic                 pop;
  req_id_e              head_id;
  logic                 sel_wr;
  logic [1:0]           sel_size;
  logic [ADDR_WD-1:0]   sel_addr;
  logic [DATA_WD-1:0]   sel_wdata;
  logic [DATA_WD/8-1:0] sel_wstrb;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
  req_id_e              last_grant;
`endif

  // A held lock overrides arbitration so the request fields never switch mid-handshake.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = ID_INST;
    if (reset) begin
      grant_valid = 1'b0;
    end else if (lock_valid) begin
      grant_valid = 1'b1;
      grant_id    = lock_id;
    end else if (inst.req && data.req) begin
      grant_valid = 1'b1;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      grant_id    = (last_grant == ID_DATA) ? ID_INST : ID_DATA;
`else
      grant_id    = ID_DATA;
`endif
    end else if (data.req) begin
      grant_valid = 1'b1;
      grant_id    = ID_DATA;
    end else if (inst.req) begin
      grant_valid = 1'b1;
      grant_id    = ID_INST;
    end
  end

  always_comb begin
    sel_wr    = 1'b0;
    sel_size  = 2'd0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_wstrb = '0;
    grant_req = 1'b0;
    if (grant_valid) begin
      if (grant_id == ID_DATA) begin
        grant_req = data.req;
        sel_wr    = data.wr;
        sel_size  = data.size;
        sel_addr  = data.addr;
        sel_wdata = data.wdata;
        sel_wstrb = data.wstrb;
      end else begin
        grant_req = inst.req;
        sel_wr    = inst.wr;
        sel_size  = inst.size;
        sel_addr  = inst.addr;
        sel_wdata = inst.wdata;
        sel_wstrb = inst.wstrb;
      end
    end
  end

  // A full FIFO stalls even when a pop lands in the same cycle.
  assign mem.req   = grant_req && (count < FULL_CNT);
  assign mem.wr    = sel_wr;
  assign mem.size  = sel_size;
  assign mem.addr  = sel_addr;
  assign mem.wdata = sel_wdata;
  assign mem.wstrb = sel_wstrb;

  assign accept       = mem.req && mem.addr_ok;
  assign inst.addr_ok = accept && (grant_id == ID_INST);
  assign data.addr_ok = accept && (grant_id == ID_DATA);

  assign pop          = mem.data_ok && (count != '0);
  assign head_id      = id_fifo[head];
  assign inst.data_ok = pop && (head_id == ID_INST);
  assign data.data_ok = pop && (head_id == ID_DATA);
  assign inst.rdata   = mem.rdata;
  assign data.rdata   = mem.rdata;

  assign arb_idle = (count == '0) && !lock_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      lock_valid <= 1'b0;
      lock_id    <= ID_INST;
      arb_err    <= 1'b0;
      for (int i = 0; i < MAX_OUTST; i++) id_fifo[i] <= ID_INST;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      last_grant <= ID_INST;
`endif
    end else begin
      if (accept) begin
        id_fifo[tail] <= grant_id;
        tail          <= tail + 1'b1;
        lock_valid    <= 1'b0;
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        last_grant    <= grant_id;
`endif
      end else if (mem.req) begin
        lock_valid <= 1'b1;
        lock_id    <= grant_id;
      end
      if (pop) head <= head + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (mem.data_ok && (count == '0)) arb_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model of the arbitration and response order.
module tb_sram_port_arbiter;
  localparam int ADDR_WD   = 32;
  localparam int DATA_WD   = 32;
  localparam int MAX_OUTST = 4;

  logic clk = 1'b0;
  logic reset;
  logic arb_idle;
  logic arb_err;
  int   checks = 0;
  int   errors = 0;

  sram_port_arbiter_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) inst_bus ();
  sram_port_arbiter_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) data_bus ();
  sram_port_arbiter_if #(.ADDR_WD(ADDR_WD), .DATA_WD(DATA_WD)) mem_bus ();

  sram_port_arbiter #(
    .ADDR_WD  (ADDR_WD),
    .DATA_WD  (DATA_WD),
    .MAX_OUTST(MAX_OUTST)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .inst    (inst_bus),
    .data    (data_bus),
    .mem     (mem_bus),
    .arb_idle(arb_idle),
    .arb_err (arb_err)
  );

  always #5 clk = ~clk;

  // Reference model: issuer order queue, pending lock owner, sticky error, last grant.
  int id_q[$];
  bit m_locked;
  int m_owner;
  bit m_err;
  int m_last;

  task automatic model_reset();
    id_q.delete();
    m_locked = 1'b0;
    m_owner  = 0;
    m_err    = 1'b0;
    m_last   = 0;
  endtask

  task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input bit ir, input bit iwr, input logic [31:0] iaddr,
                                input bit dr, input bit dwr, input logic [31:0] daddr,
                                input bit aok, input bit dok, input logic [31:0] rdata);
    inst_bus.req     = ir;
    inst_bus.wr      = iwr;
    inst_bus.size    = 2'd2;
    inst_bus.addr    = iaddr;
    inst_bus.wdata   = iaddr ^ 32'h5A5A_0000;
    inst_bus.wstrb   = 4'hF;
    data_bus.req     = dr;
    data_bus.wr      = dwr;
    data_bus.size    = 2'd2;
    data_bus.addr    = daddr;
    data_bus.wdata   = daddr ^ 32'hA5A5_0000;
    data_bus.wstrb   = 4'hF;
    mem_bus.addr_ok  = aok;
    mem_bus.data_ok  = dok;
    mem_bus.rdata    = rdata;
    #1;
  endtask

  // Predict this cycle's outputs from the model, compare, then clock and advance the model.
  task automatic run_cycle();
    int g;
    bit has_g;
    bit e_req;
    bit acc;
    bit pop;
    bit err_now;
    int head;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_wr;
    has_g = 1'b1;
    g     = 0;
    if (m_locked) g = m_owner;
    else if (inst_bus.req && data_bus.req) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
      g = 1 - m_last;
`else
      g = 1;
`endif
    end
    else if (data_bus.req) g = 1;
    else if (inst_bus.req) g = 0;
    else has_g = 1'b0;
    e_req   = has_g && ((g == 1) ? data_bus.req : inst_bus.req) && (id_q.size() < MAX_OUTST);
    acc     = e_req && mem_bus.addr_ok;
    pop     = mem_bus.data_ok && (id_q.size() > 0);
    err_now = mem_bus.data_ok && (id_q.size() == 0);
    head    = (id_q.size() > 0) ? id_q[0] : -1;
    e_addr  = !has_g ? 32'h0 : (g == 1) ? data_bus.addr  : inst_bus.addr;
    e_wdata = !has_g ? 32'h0 : (g == 1) ? data_bus.wdata : inst_bus.wdata;
    e_wr    = !has_g ? 1'b0  : (g == 1) ? data_bus.wr    : inst_bus.wr;
    check_output("mem_req",      mem_bus.req,      e_req);
    check_output("mem_addr",     mem_bus.addr,     e_addr);
    check_output("mem_wdata",    mem_bus.wdata,    e_wdata);
    check_output("mem_wr",       mem_bus.wr,       e_wr);
    check_output("inst_addr_ok", inst_bus.addr_ok, acc && (g == 0));
    check_output("data_addr_ok", data_bus.addr_ok, acc && (g == 1));
    check_output("inst_data_ok", inst_bus.data_ok, pop && (head == 0));
    check_output("data_data_ok", data_bus.data_ok, pop && (head == 1));
    check_output("inst_rdata",   inst_bus.rdata,   mem_bus.rdata);
    check_output("data_rdata",   data_bus.rdata,   mem_bus.rdata);
    check_output("arb_idle",     arb_idle,         (id_q.size() == 0) && !m_locked);
    check_output("arb_err",      arb_err,          m_err);
    @(posedge clk);
    if (pop) void'(id_q.pop_front());
    if (err_now) m_err = 1'b1;
    if (acc) begin
      id_q.push_back(g);
      m_locked = 1'b0;
      m_last   = g;
    end else if (e_req) begin
      m_locked = 1'b1;
      m_owner  = g;
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    model_reset();
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    #2;
    check_output("reset_idle", arb_idle, 1'b1);
    check_output("reset_err",  arb_err,  1'b0);
    check_output("reset_mreq", mem_bus.req, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;

    // Single read, response two cycles after accept
    apply_stimulus(1, 0, 32'h1C00_0000, 0, 0, 32'h0, 1, 0, 32'h0);
    check_output("single_accept", inst_bus.addr_ok, 1'b1);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h0280_0C0C);
    check_output("single_inst_dok",  inst_bus.data_ok, 1'b1);
    check_output("single_inst_data", inst_bus.rdata,   32'h0280_0C0C);
    check_output("single_data_dok",  data_bus.data_ok, 1'b0);
    run_cycle();

    // Contention: data write wins, inst follows
    apply_stimulus(1, 0, 32'h1C00_0004, 1, 1, 32'h1C00_8000, 1, 0, 32'h0);
    check_output("cont_addr",    mem_bus.addr,     32'h1C00_8000);
    check_output("cont_wr",      mem_bus.wr,       1'b1);
    check_output("cont_data_ok", data_bus.addr_ok, 1'b1);
    check_output("cont_inst_ok", inst_bus.addr_ok, 1'b0);
    run_cycle();
    apply_stimulus(1, 0, 32'h1C00_0004, 0, 0, 32'h0, 1, 0, 32'h0);
    check_output("cont_inst_next", inst_bus.addr_ok, 1'b1);
    run_cycle();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h1111_0000 + i);
      run_cycle();
    end

    // Lock: inst stalled by memory while data_req rises
    apply_stimulus(1, 0, 32'h1C00_0010, 0, 0, 32'h0, 0, 0, 32'h0);
    run_cycle();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(1, 0, 32'h1C00_0010, 1, 0, 32'h1C00_9000, 0, 0, 32'h0);
      check_output("lock_addr",    mem_bus.addr,     32'h1C00_0010);
      check_output("lock_no_data", data_bus.addr_ok, 1'b0);
      run_cycle();
    end
    apply_stimulus(1, 0, 32'h1C00_0010, 1, 0, 32'h1C00_9000, 1, 0, 32'h0);
    check_output("lock_inst_acc", inst_bus.addr_ok, 1'b1);
    check_output("lock_data_acc", data_bus.addr_ok, 1'b0);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 1, 0, 32'h1C00_9000, 1, 0, 32'h0);
    check_output("lock_data_after", data_bus.addr_ok, 1'b1);
    run_cycle();
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h2222_0000 + i);
      run_cycle();
    end

    // Ordering: inst, data, inst issued then answered back-to-back
    apply_stimulus(1, 0, 32'h1C00_0020, 0, 0, 32'h0, 1, 0, 32'h0);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 1, 0, 32'h1C00_A000, 1, 0, 32'h0);
    run_cycle();
    apply_stimulus(1, 0, 32'h1C00_0024, 0, 0, 32'h0, 1, 0, 32'h0);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h3333_0001);
    check_output("order_1_inst", inst_bus.data_ok, 1'b1);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h3333_0002);
    check_output("order_2_data", data_bus.data_ok, 1'b1);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h3333_0003);
    check_output("order_3_inst", inst_bus.data_ok, 1'b1);
    run_cycle();

    // Full stall: no bypass on a same-cycle pop
    for (int i = 0; i < MAX_OUTST; i++) begin
      apply_stimulus(1, 0, 32'h1C00_0100 + 4 * i, 0, 0, 32'h0, 1, 0, 32'h0);
      run_cycle();
    end
    apply_stimulus(1, 0, 32'h1C00_0200, 0, 0, 32'h0, 1, 0, 32'h0);
    check_output("full_stall", mem_bus.req, 1'b0);
    run_cycle();
    apply_stimulus(1, 0, 32'h1C00_0200, 0, 0, 32'h0, 1, 1, 32'h4444_0000);
    check_output("full_pop_stall", mem_bus.req, 1'b0);
    run_cycle();
    apply_stimulus(1, 0, 32'h1C00_0200, 0, 0, 32'h0, 1, 0, 32'h0);
    check_output("full_resume", mem_bus.req, 1'b1);
    run_cycle();
    for (int i = 0; i < MAX_OUTST; i++) begin
      apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h4444_0010 + i);
      run_cycle();
    end

    // Randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                     1'($urandom_range(0, 1)),
                     (id_q.size() > 0) && (1'($urandom_range(0, 1)) == 1'b1), $urandom);
      run_cycle();
    end

    // Drain outstanding responses and any held lock
    for (int i = 0; i < MAX_OUTST && id_q.size() > 0; i++) begin
      apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h5555_0000 + i);
      run_cycle();
    end
    if (m_locked) begin
      apply_stimulus(m_owner == 0, 0, 32'h1C00_0300, m_owner == 1, 0, 32'h1C00_B000, 1, 0, 32'h0);
      run_cycle();
      apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h5555_00FF);
      run_cycle();
    end

    // Spurious response with empty FIFO sets sticky error
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h6666_0000);
    check_output("err_no_inst_dok", inst_bus.data_ok, 1'b0);
    check_output("err_no_data_dok", data_bus.data_ok, 1'b0);
    run_cycle();
    check_output("err_set", arb_err, 1'b1);
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 0, 32'h0);
    run_cycle();
    check_output("err_sticky", arb_err, 1'b1);

    // Asynchronous reset in the middle of a transaction
    apply_stimulus(1, 0, 32'h1C00_0400, 0, 0, 32'h0, 1, 0, 32'h0);
    run_cycle();
    apply_stimulus(1, 0, 32'h1C00_0404, 1, 0, 32'h1C00_C000, 0, 0, 32'h0);
    run_cycle();
    mem_bus.data_ok = 1'b1;
    mem_bus.addr_ok = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check_output("areset_err",      arb_err,          1'b0);
    check_output("areset_idle",     arb_idle,         1'b1);
    check_output("areset_mreq",     mem_bus.req,      1'b0);
    check_output("areset_maddr",    mem_bus.addr,     32'h0);
    check_output("areset_iaok",     inst_bus.addr_ok, 1'b0);
    check_output("areset_daok",     data_bus.addr_ok, 1'b0);
    check_output("areset_idok",     inst_bus.data_ok, 1'b0);
    check_output("areset_ddok",     data_bus.data_ok, 1'b0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    apply_stimulus(1, 0, 32'h1C00_0500, 0, 0, 32'h0, 1, 0, 32'h0);
    run_cycle();
    apply_stimulus(0, 0, 32'h0, 0, 0, 32'h0, 0, 1, 32'h7777_0000);
    run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
